// File: rtl/dmem_mmio_responder.sv
// MMIO responder for the CPU data-memory bus: cycle counter, scratch register
// and a write-only result FIFO drained through a valid/ready stream port.
module dmem_mmio_responder #(
  parameter int         DEPTH   = 8,
  parameter logic [1:0] BASE_HI = 2'b11
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [9:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mmio_hit,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] OFF_CYCLE   = 8'h00;
  localparam logic [7:0] OFF_FIFO    = 8'h04;
  localparam logic [7:0] OFF_STATUS  = 8'h08;
  localparam logic [7:0] OFF_STS_CLR = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH = 8'h10;

  logic [31:0]      cycle_q;
  logic [31:0]      scratch_q;
  logic [31:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic [7:0]  offset;
  logic        wr_hit;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_req;
  logic        push_ok;
  logic        ovf_set;
  logic        ovf_clr;
  logic        scratch_we;
  logic [31:0] status;
  logic        unused_addr_lsb;

  // Word access only: the byte-lane bits take no part in decode.
  assign offset          = {address[7:2], 2'b00};
  assign unused_addr_lsb = ^address[1:0];
  assign mmio_hit        = (address[9:8] == BASE_HI);
  assign wr_hit          = MemWrite & mmio_hit;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = empty ? 32'd0 : fifo_mem[rd_ptr];
  assign pop       = out_valid & out_ready;

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign push_req   = wr_hit && (offset == OFF_FIFO);
  assign push_ok    = push_req && (!full || pop);
  assign ovf_set    = push_req && full && !pop;
  assign ovf_clr    = wr_hit && (offset == OFF_STS_CLR) && write_data[2];
  assign scratch_we = wr_hit && (offset == OFF_SCRATCH);

  always_comb begin
    status             = '0;
    status[0]          = empty;
    status[1]          = full;
    status[2]          = ovf_q;
    status[8 +: CNT_W] = count_q;
  end

  always_comb begin
    read_data = '0;
    if (MemRead && mmio_hit) begin
      case (offset)
        OFF_CYCLE:   read_data = cycle_q;
        OFF_STATUS:  read_data = status;
        OFF_SCRATCH: read_data = scratch_q;
        default:     read_data = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cycle_q   <= '0;
      scratch_q <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (scratch_we) scratch_q <= write_data;
      if (push_ok)    wr_ptr    <= wr_ptr + 1'b1;
      if (pop)        rd_ptr    <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A new overflow takes priority over a clear in the same cycle.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

endmodule
